// File: rtl/proteus_pkg.sv
// Purpose:      shared defaults, types and helpers for the Proteus SB unpack path.
// Latency:      n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   N_DEF / TN_DEF / W_IN_DEF / PREC_W : default value width, Tn row width,
//                                        packed word width, precision field width
//   ext_mode_e                         : zero- or sign-extension of narrow values
//   clog2()                            : elaboration-time ceil(log2())
package proteus_pkg;

  localparam int N_DEF    = 16;   // unpacked value width
  localparam int TN_DEF   = 16;   // values per output row (Tn)
  localparam int W_IN_DEF = 256;  // packed SB word width
  localparam int PREC_W   = 5;    // precision field width, 2**PREC_W > N_DEF

  typedef enum logic {
    EXT_ZERO = 1'b0,
    EXT_SIGN = 1'b1
  } ext_mode_e;

  // Smallest r with 2**r >= value; used only for parameter sizing.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/proteus_sb_lane_ext.sv
// Purpose:      widen one reduced-precision value (prec LSBs of raw) to N bits.
// Latency:      combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   prec  in  PW  number of valid LSBs in raw (caller guarantees 1..N)
//   mode  in  1   EXT_SIGN replicates bit prec-1 upward, EXT_ZERO clears it
//   raw   in  N   window of the bit buffer starting at this lane's value
//   ext   out N   extended value; prec == N passes raw straight through
module proteus_sb_lane_ext
  import proteus_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int PW = PREC_W
) (
  input  logic [PW-1:0] prec,
  input  ext_mode_e     mode,
  input  logic [N-1:0]  raw,
  output logic [N-1:0]  ext
);

  logic msb;

  always_comb begin
    // Pick the value's top bit (index prec-1) without a variable bit-select,
    // so the index width never has to match the vector width.
    msb = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (PW'(i + 1) == prec) begin
        msb = raw[i];
      end
    end

    ext = '0;
    for (int i = 0; i < N; i++) begin
      if (PW'(i) < prec) begin
        ext[i] = raw[i];
      end else begin
        ext[i] = (mode == EXT_SIGN) ? msb : 1'b0;
      end
    end
  end

endmodule

// File: rtl/proteus_sb_unpack_stream.sv
// Purpose:      unpack a dense P-bit/value SB stream into LANES x N-bit rows for NFU-1.
// Latency:      word accepted into an empty buffer at edge e -> row valid after edge e+1.
// Backpressure: o_pk_ready drops while more than one word is buffered; the row is held while i_ready is low.
//
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   i_cfg_load        latch i_cfg_prec / i_cfg_signed and flush buffer + pending row
//   i_cfg_prec        bits per packed value P (legal 1..N; otherwise N is used)
//   i_cfg_signed      1 = sign-extend, 0 = zero-extend
//   i_pk_data/valid   packed input word (value 0 at LSB) and its valid
//   o_pk_ready        buffer can take a word this cycle
//   o_data/o_valid    unpacked row (lane k at [k*N +: N]) and its valid
//   i_ready           consumer accepts the row
//   o_cfg_err         sticky flag: an illegal precision was loaded
module proteus_sb_unpack_stream
  import proteus_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int LANES = TN_DEF,
  parameter int W_IN  = W_IN_DEF,
  parameter int PW    = PREC_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_cfg_load,
  input  logic [PW-1:0]        i_cfg_prec,
  input  logic                 i_cfg_signed,
  input  logic [W_IN-1:0]      i_pk_data,
  input  logic                 i_pk_valid,
  output logic                 o_pk_ready,
  output logic [N*LANES-1:0]   o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_cfg_err
);

  // Two words of storage: a full word can always be appended while up to one
  // word's worth of bits is still waiting to form a row.
  localparam int BUF_W = 2 * W_IN;
  localparam int FW    = clog2(BUF_W + 1);

  logic [BUF_W-1:0] bit_buf_q;
  logic [FW-1:0]    fill_q;
  logic [PW-1:0]    prec_q;
  ext_mode_e        mode_q;

  logic [FW-1:0]    need;
  logic             row_load;
  logic             pk_fire;
  logic [BUF_W-1:0] buf_shift;
  logic [FW-1:0]    fill_shift;
  logic [BUF_W-1:0] buf_next;
  logic [FW-1:0]    fill_next;
  logic             cfg_legal;
  logic [PW-1:0]    cfg_prec;

  logic [LANES-1:0][N-1:0] lane_raw;
  logic [LANES-1:0][N-1:0] lane_ext;

  // Bits consumed by one row at the current precision.
  assign need = FW'(LANES) * FW'(prec_q);

  // A pending configuration load blocks input so no word lands in a buffer
  // that is about to be flushed.
  assign o_pk_ready = (fill_q <= FW'(W_IN)) && !i_cfg_load;
  assign pk_fire    = i_pk_valid && o_pk_ready;
  assign row_load   = (fill_q >= need) && (!o_valid || i_ready);

  assign cfg_legal = (i_cfg_prec != '0) && (i_cfg_prec <= PW'(N));
  assign cfg_prec  = cfg_legal ? i_cfg_prec : PW'(N);

  // Consume first, then append the incoming word directly above what is left.
  // Bits above fill are always zero (reset/flush clear them and the right
  // shift fills with zeros), so the append can simply be OR-ed in.
  always_comb begin
    buf_shift  = bit_buf_q;
    fill_shift = fill_q;
    if (row_load) begin
      buf_shift  = bit_buf_q >> need;
      fill_shift = fill_q - need;
    end

    buf_next  = buf_shift;
    fill_next = fill_shift;
    if (pk_fire) begin
      buf_next  = buf_shift | ({{W_IN{1'b0}}, i_pk_data} << fill_shift);
      fill_next = fill_shift + FW'(W_IN);
    end
  end

  // Lane k's value starts k*prec bits up; take an N-bit window there and let
  // the extender keep only the prec LSBs.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_raw[k] = N'(bit_buf_q >> (k * int'(prec_q)));

    proteus_sb_lane_ext #(
      .N  (N),
      .PW (PW)
    ) u_ext (
      .prec (prec_q),
      .mode (mode_q),
      .raw  (lane_raw[k]),
      .ext  (lane_ext[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_buf_q <= '0;
      fill_q    <= '0;
      prec_q    <= PW'(N);
      mode_q    <= EXT_SIGN;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_cfg_err <= 1'b0;
    end else if (i_cfg_load) begin
      // New layer: residual bits and any unconsumed row belong to the old one.
      bit_buf_q <= '0;
      fill_q    <= '0;
      o_valid   <= 1'b0;
      prec_q    <= cfg_prec;
      mode_q    <= i_cfg_signed ? EXT_SIGN : EXT_ZERO;
      if (!cfg_legal) begin
        o_cfg_err <= 1'b1;
      end
    end else begin
      bit_buf_q <= buf_next;
      fill_q    <= fill_next;
      if (row_load) begin
        o_data  <= lane_ext;
        o_valid <= 1'b1;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_proteus_sb_unpack_stream.sv
module tb_proteus_sb_unpack_stream;
  import proteus_pkg::*;

  localparam int N     = 16;
  localparam int LANES = 16;
  localparam int W_IN  = 256;
  localparam int PW    = 5;
  localparam int RW    = N * LANES;

  logic            clk;
  logic            rst_n;
  logic            i_cfg_load;
  logic [PW-1:0]   i_cfg_prec;
  logic            i_cfg_signed;
  logic [W_IN-1:0] i_pk_data;
  logic            i_pk_valid;
  logic            o_pk_ready;
  logic [RW-1:0]   o_data;
  logic            o_valid;
  logic            i_ready;
  logic            o_cfg_err;

  proteus_sb_unpack_stream #(
    .N(N), .LANES(LANES), .W_IN(W_IN), .PW(PW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cfg_load   (i_cfg_load),
    .i_cfg_prec   (i_cfg_prec),
    .i_cfg_signed (i_cfg_signed),
    .i_pk_data    (i_pk_data),
    .i_pk_valid   (i_pk_valid),
    .o_pk_ready   (o_pk_ready),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_cfg_err    (o_cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a plain bit queue (LSB first) that is cut into rows of
  // LANES values of m_prec bits each, widened with integer arithmetic.
  bit            bq[$];
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] act_q[$];
  int            m_prec   = N;
  bit            m_signed = 1'b1;

  function automatic logic [W_IN-1:0] rand_word();
    logic [W_IN-1:0] w;
    for (int j = 0; j < W_IN / 32; j++) w[j*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic model_push(input logic [W_IN-1:0] w);
    logic [RW-1:0] row;
    int v;
    for (int i = 0; i < W_IN; i++) bq.push_back(w[i]);
    while (bq.size() >= LANES * m_prec) begin
      row = '0;
      for (int k = 0; k < LANES; k++) begin
        v = 0;
        for (int j = 0; j < m_prec; j++) v = v + (int'(bq.pop_front()) << j);
        if (m_signed && v >= (1 << (m_prec - 1))) v = v - (1 << m_prec);
        row[k*N +: N] = v[N-1:0];
      end
      exp_q.push_back(row);
    end
  endtask

  task automatic model_flush();
    bq.delete();
    exp_q.delete();
    act_q.delete();
  endtask

  // One clock: drive at the falling edge, record what the next rising edge does.
  task automatic step(input logic pv, input logic [W_IN-1:0] pd, input logic rdy,
                      output bit fired);
    @(negedge clk);
    i_cfg_load = 1'b0;
    i_pk_valid = pv;
    i_pk_data  = pd;
    i_ready    = rdy;
    #1;
    fired = i_pk_valid && o_pk_ready;
    if (o_valid && i_ready) act_q.push_back(o_data);
    if (fired) model_push(pd);
  endtask

  task automatic drain(input int cycles);
    bit f;
    for (int c = 0; c < cycles; c++) step(1'b0, '0, 1'b1, f);
  endtask

  task automatic send_word(input logic [W_IN-1:0] w, input logic rdy);
    bit f;
    int t;
    f = 1'b0;
    t = 0;
    while (!f && t < 50) begin
      step(1'b1, w, rdy, f);
      t++;
    end
    if (!f) begin
      n_cmp++; n_err++;
      $display("FAIL send_word: not accepted after %0d cycles", t);
    end
  endtask

  task automatic cfg(input int p, input bit s);
    @(negedge clk);
    i_cfg_load   = 1'b1;
    i_cfg_prec   = p[PW-1:0];
    i_cfg_signed = s;
    i_pk_valid   = 1'b0;
    i_ready      = 1'b0;
    #1;
    model_flush();
    m_prec   = (p < 1 || p > N) ? N : p;
    m_signed = s;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_cfg_load = 1'b0; i_cfg_prec = '0; i_cfg_signed = 1'b0;
    i_pk_data = '0; i_pk_valid = 1'b0; i_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_data !== '0) begin n_err++; $display("FAIL rst_data: got %h want 0", o_data); end
    n_cmp++; if (o_cfg_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", o_cfg_err); end
    n_cmp++; if (o_pk_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", o_pk_ready); end
  endtask

  task automatic test_full_prec();
    logic [W_IN-1:0] w;
    bit f;
    for (int k = 0; k < LANES; k++) w[k*16 +: 16] = 16'(k + 1);
    cfg(16, 1'b0);
    step(1'b1, w, 1'b0, f);
    step(1'b0, '0, 1'b0, f);
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL t1_early_valid: got %b want 0", o_valid); end
    step(1'b0, '0, 1'b0, f);
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL t1_valid: got %b want 1", o_valid); end
    n_cmp++; if (o_data !== w) begin n_err++; $display("FAIL t1_row: got %h want %h", o_data, w); end
    drain(4);
    n_cmp++; if (act_q.size() != 1) begin n_err++; $display("FAIL t1_rows: got %0d want 1", act_q.size()); end
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL t1_empty: got %b want 0", o_valid); end
  endtask

  task automatic test_prec4_signed();
    logic [W_IN-1:0] w;
    logic [RW-1:0]   exp_row;
    bit f;
    w       = {32{8'h7F}};
    exp_row = {8{32'h0007_FFFF}};
    cfg(4, 1'b1);
    step(1'b1, w, 1'b1, f);
    for (int c = 0; c < 8; c++) begin
      step(1'b0, '0, 1'b1, f);
      n_cmp++; if (o_pk_ready !== 1'b1) begin n_err++; $display("FAIL t2_ready cyc %0d: got %b want 1", c, o_pk_ready); end
    end
    n_cmp++; if (act_q.size() != 4) begin n_err++; $display("FAIL t2_rows: got %0d want 4", act_q.size()); end
    foreach (act_q[i]) begin
      n_cmp++;
      if (act_q[i] !== exp_row) begin n_err++; $display("FAIL t2_row%0d: got %h want %h", i, act_q[i], exp_row); end
    end
  endtask

  task automatic test_prec5_straddle();
    cfg(5, 1'b0);
    for (int i = 0; i < 3; i++) send_word(rand_word(), 1'b1);
    drain(20);
    n_cmp++; if (act_q.size() != 9) begin n_err++; $display("FAIL t3_rows9: got %0d want 9", act_q.size()); end
    send_word(rand_word(), 1'b1);
    drain(20);
    n_cmp++; if (act_q.size() != 12) begin n_err++; $display("FAIL t3_rows12: got %0d want 12", act_q.size()); end
    n_cmp++; if (act_q.size() != exp_q.size()) begin n_err++; $display("FAIL t3_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (act_q[i] !== exp_q[i]) begin n_err++; $display("FAIL t3_row%0d: got %h want %h", i, act_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [W_IN-1:0] cur;
    logic [RW-1:0]   held;
    bit f, saw_drop;
    cfg(16, 1'b1);
    cur = rand_word();
    for (int c = 0; c < 4; c++) begin
      step(1'b1, cur, 1'b1, f);
      if (f) cur = rand_word();
    end
    saw_drop = 1'b0;
    held = o_data;
    for (int c = 0; c < 10; c++) begin
      step(1'b1, cur, 1'b0, f);
      if (f) cur = rand_word();
      if (!o_pk_ready) saw_drop = 1'b1;
      if (c == 0) held = o_data;
      n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL t4_hold_valid cyc %0d: got %b want 1", c, o_valid); end
      n_cmp++; if (o_data !== held) begin n_err++; $display("FAIL t4_stable cyc %0d: got %h want %h", c, o_data, held); end
    end
    n_cmp++; if (saw_drop !== 1'b1) begin n_err++; $display("FAIL t4_ready_drop: got %b want 1", saw_drop); end
    for (int c = 0; c < 10; c++) begin
      step(1'b1, cur, 1'b1, f);
      if (f) cur = rand_word();
    end
    drain(40);
    n_cmp++; if (act_q.size() != exp_q.size()) begin n_err++; $display("FAIL t4_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (act_q[i] !== exp_q[i]) begin n_err++; $display("FAIL t4_row%0d: got %h want %h", i, act_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [W_IN-1:0] cur;
    bit f;
    for (int r = 0; r < 6; r++) begin
      cfg(int'($urandom_range(1, 16)), 1'($urandom_range(0, 1)));
      cur = rand_word();
      for (int c = 0; c < 80; c++) begin
        step(1'($urandom_range(0, 1)), cur, ($urandom_range(0, 3) != 0), f);
        if (f) cur = rand_word();
      end
      drain(40);
      n_cmp++; if (act_q.size() != exp_q.size()) begin n_err++; $display("FAIL rnd%0d_count p=%0d: got %0d want %0d", r, m_prec, act_q.size(), exp_q.size()); end
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
        n_cmp++;
        if (act_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rnd%0d_row%0d p=%0d s=%0d: got %h want %h", r, i, m_prec, m_signed, act_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_cfg_err();
    logic [W_IN-1:0] w;
    bit f;
    cfg(5, 1'b0);
    for (int i = 0; i < 3; i++) send_word(rand_word(), 1'b1);
    drain(20);
    n_cmp++; if (act_q.size() != exp_q.size()) begin n_err++; $display("FAIL t5_pre_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (act_q[i] !== exp_q[i]) begin n_err++; $display("FAIL t5_pre_row%0d: got %h want %h", i, act_q[i], exp_q[i]); end
    end
    send_word(rand_word(), 1'b0);
    for (int c = 0; c < 3; c++) step(1'b0, '0, 1'b0, f);
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL t5_pending: got %b want 1", o_valid); end
    cfg(0, 1'b0);
    n_cmp++; if (o_pk_ready !== 1'b0) begin n_err++; $display("FAIL t5_ready_in_load: got %b want 0", o_pk_ready); end
    step(1'b0, '0, 1'b0, f);
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL t5_valid_drop: got %b want 0", o_valid); end
    n_cmp++; if (o_cfg_err !== 1'b1) begin n_err++; $display("FAIL t5_cfg_err: got %b want 1", o_cfg_err); end
    w = rand_word();
    send_word(w, 1'b1);
    drain(10);
    n_cmp++; if (act_q.size() != 1) begin n_err++; $display("FAIL t5_rows: got %0d want 1", act_q.size()); end
    if (act_q.size() > 0) begin
      n_cmp++; if (act_q[0] !== w) begin n_err++; $display("FAIL t5_p16_row: got %h want %h", act_q[0], w); end
    end
    n_cmp++; if (o_cfg_err !== 1'b1) begin n_err++; $display("FAIL t5_err_sticky: got %b want 1", o_cfg_err); end
  endtask

  task automatic test_reset_mid();
    logic [W_IN-1:0] w;
    bit f;
    cfg(5, 1'b0);
    send_word(rand_word(), 1'b0);
    send_word(rand_word(), 1'b0);
    step(1'b0, '0, 1'b0, f);
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL t6_pre_valid: got %b want 1", o_valid); end
    @(negedge clk);
    rst_n = 1'b0; i_pk_valid = 1'b0; i_ready = 1'b0; i_cfg_load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    model_flush();
    m_prec = N; m_signed = 1'b1;
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL t6_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_data !== '0) begin n_err++; $display("FAIL t6_data: got %h want 0", o_data); end
    n_cmp++; if (o_cfg_err !== 1'b0) begin n_err++; $display("FAIL t6_err: got %b want 0", o_cfg_err); end
    n_cmp++; if (o_pk_ready !== 1'b1) begin n_err++; $display("FAIL t6_ready: got %b want 1", o_pk_ready); end
    // Default precision is N with an empty buffer: one word is one verbatim row.
    w = rand_word();
    send_word(w, 1'b1);
    drain(10);
    n_cmp++; if (act_q.size() != 1) begin n_err++; $display("FAIL t6_rows: got %0d want 1", act_q.size()); end
    if (act_q.size() > 0) begin
      n_cmp++; if (act_q[0] !== w) begin n_err++; $display("FAIL t6_row: got %h want %h", act_q[0], w); end
    end
  endtask

  initial begin
    test_reset();
    test_full_prec();
    test_prec4_signed();
    test_prec5_straddle();
    test_backpressure();
    test_random();
    test_cfg_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
